// File: rtl/quad_pkg.sv
// Shared definitions for the QuadCopter host command path: packet FSM states,
// packet framing constants, default bit timing and command byte encodings.
package quad_pkg;

    localparam int unsigned PKT_BYTES        = 3;
    localparam int unsigned BAUD_DIV_DEFAULT = 2604;
    localparam int unsigned GAP_CNT_W        = 24;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } pkt_state_t;

    // Completed command packet as presented to the command processor
    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] data;
    } cmd_pkt_t;

    localparam logic [7:0] STPTCH    = 8'h02;
    localparam logic [7:0] STROLL    = 8'h03;
    localparam logic [7:0] STYAW     = 8'h04;
    localparam logic [7:0] STTHST    = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMRLND    = 8'h07;
    localparam logic [7:0] MTSOFF    = 8'h08;

endpackage

// File: rtl/uart.sv
// 8N1 byte transceiver. RX is synchronised, then each bit is sampled at the
// middle of its bit time; TX shifts out start, 8 data bits LSB first, stop.
module uart
    import quad_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    input  logic       clr_rx_rdy,
    input  logic [7:0] tx_data,
    input  logic       trmt,
    output logic       tx_done
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    logic             rx_s1;
    logic             rx_s2;
    logic             rx_busy;
    logic [CNT_W-1:0] rx_cnt;
    logic [3:0]       rx_bit;
    logic [7:0]       rx_shift;

    logic             tx_busy;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic [8:0]       tx_shift;

    // Receiver: double-flop RX, detect start, sample mid-bit, flag byte mid-stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_busy  <= 1'b0;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            rx_s1 <= RX;
            rx_s2 <= rx_s1;
            if (clr_rx_rdy) begin
                rx_rdy <= 1'b0;
            end
            if (!rx_busy) begin
                if (!rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= HALF_LAST;
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - CNT_W'(1);
            end else begin
                rx_cnt <= BIT_LAST;
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0) begin
                    // glitch rather than a real start bit
                    if (rx_s2) begin
                        rx_busy <= 1'b0;
                    end
                end else if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                    if (rx_s2) begin
                        rx_data <= rx_shift;
                        rx_rdy  <= 1'b1;
                    end
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                end
            end
        end
    end

    // Transmitter: frame starts the clock after trmt, done flags after stop bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TX       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_done  <= 1'b0;
        end else if (!tx_busy) begin
            if (trmt) begin
                TX       <= 1'b0;
                tx_busy  <= 1'b1;
                tx_cnt   <= '0;
                tx_bit   <= '0;
                tx_shift <= {1'b1, tx_data};
                tx_done  <= 1'b0;
            end
        end else if (tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + CNT_W'(1);
        end else begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                TX      <= 1'b1;
                tx_busy <= 1'b0;
                tx_done <= 1'b1;
            end else begin
                TX       <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[8:1]};
                tx_bit   <= tx_bit + 4'd1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Host command front end: assembles 3-byte packets {cmd, data_hi, data_lo}
// from the UART into cmd/data with a cmd_rdy flag, and sends 1-byte responses.
// Optional feature macro CMD_TIMEOUT_EN: abandon a partial packet when the gap
// between its bytes reaches TIMEOUT_CYC clocks.
module uart_cmd_wrapper
    import quad_pkg::*;
#(
    parameter int unsigned BAUD_DIV    = BAUD_DIV_DEFAULT,
    parameter logic [23:0] TIMEOUT_CYC = 24'd2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    // Elaboration guard on the timing parameters
    if (BAUD_DIV < 4 || TIMEOUT_CYC == 24'd0 || PKT_BYTES != 3) begin : g_bad_param
        $error("uart_cmd_wrapper: invalid BAUD_DIV or TIMEOUT_CYC");
    end

    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       clr_rx_rdy;

    pkt_state_t state;
    pkt_state_t nxt_state;
    logic [7:0] cmd_shadow;
    logic [7:0] nxt_cmd_shadow;
    logic [7:0] data_hi;
    logic [7:0] nxt_data_hi;
    cmd_pkt_t   pkt;
    cmd_pkt_t   nxt_pkt;
    logic       nxt_cmd_rdy;

`ifdef CMD_TIMEOUT_EN
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic [GAP_CNT_W-1:0] nxt_gap_cnt;
`endif

    uart #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .TX         (TX),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy),
        .tx_data    (resp),
        .trmt       (send_resp),
        .tx_done    (resp_sent)
    );

    assign cmd  = pkt.cmd;
    assign data = pkt.data;

    // Packet state and holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_shadow <= '0;
            data_hi    <= '0;
            pkt        <= '0;
            cmd_rdy    <= 1'b0;
        end else begin
            state      <= nxt_state;
            cmd_shadow <= nxt_cmd_shadow;
            data_hi    <= nxt_data_hi;
            pkt        <= nxt_pkt;
            cmd_rdy    <= nxt_cmd_rdy;
        end
    end

`ifdef CMD_TIMEOUT_EN
    // Inter-byte gap counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= nxt_gap_cnt;
        end
    end
`endif

    // Next-state: every received byte is consumed the cycle it appears
    always_comb begin
        nxt_state      = state;
        nxt_cmd_shadow = cmd_shadow;
        nxt_data_hi    = data_hi;
        nxt_pkt        = pkt;
        nxt_cmd_rdy    = cmd_rdy & ~clr_cmd_rdy;
        clr_rx_rdy     = rx_rdy;
`ifdef CMD_TIMEOUT_EN
        nxt_gap_cnt    = '0;
`endif
        case (state)
            IDLE: begin
                if (rx_rdy) begin
                    nxt_cmd_shadow = rx_data;
                    nxt_cmd_rdy    = 1'b0;
                    nxt_state      = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (rx_rdy) begin
                    nxt_data_hi = rx_data;
                    nxt_state   = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (rx_rdy) begin
                    nxt_pkt.cmd  = cmd_shadow;
                    nxt_pkt.data = {data_hi, rx_data};
                    nxt_cmd_rdy  = 1'b1;
                    nxt_state    = IDLE;
                end
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
`ifdef CMD_TIMEOUT_EN
        // A byte arriving on the limit cycle still wins over the timeout
        if (state != IDLE && !rx_rdy) begin
            if (gap_cnt == TIMEOUT_CYC) begin
                nxt_state      = IDLE;
                nxt_cmd_shadow = '0;
                nxt_data_hi    = '0;
            end else begin
                nxt_gap_cnt = gap_cnt + GAP_CNT_W'(1);
            end
        end
`endif
    end

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Bench for uart_cmd_wrapper: packet table plus response, timeout and reset
// sequences. Expected packets are queued when sent and popped on cmd_rdy rise.
module tb_uart_cmd_wrapper;
    import quad_pkg::*;

    localparam int unsigned BD    = 16;
    localparam logic [23:0] TO    = 24'd200;
    localparam int unsigned FRAME = 10 * BD;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b1;
    logic        RX          = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp   = 1'b0;
    logic [7:0]  resp        = 8'h00;
    logic        TX;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cmd_rdy;
    logic        resp_sent;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rx_rise = -100;
    logic prev_rx  = 1'b0;
    logic prev_rdy = 1'b0;
    cmd_pkt_t exp_q[$];
    cmd_pkt_t sb_e;

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        logic [7:0]  exp_cmd;
        logic [15:0] exp_data;
        bit          clr_after;
    } vec_t;
    vec_t vecs[5];

    uart_cmd_wrapper #(
        .BAUD_DIV    (BD),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .data        (data),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: on every cmd_rdy rise check latency and the packet contents
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (dut.u_uart.rx_rdy && !prev_rx) begin
                last_rx_rise = cyc;
            end
            if (cmd_rdy && !prev_rdy) begin
                chk("rdy_latency", 32'(cyc - last_rx_rise), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=%0h/%0h required=none", cmd, data);
                end else begin
                    sb_e = exp_q.pop_front();
                    chk("sb_cmd", 32'(cmd), 32'(sb_e.cmd));
                    chk("sb_data", 32'(data), 32'(sb_e.data));
                end
            end
        end
        prev_rx  = dut.u_uart.rx_rdy;
        prev_rdy = cmd_rdy;
    end

    task automatic push(input logic [7:0] c, input logic [15:0] d);
        cmd_pkt_t p;
        p.cmd  = c;
        p.data = d;
        exp_q.push_back(p);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = f[i];
            repeat (BD - 1) @(negedge clk);
        end
    endtask

    task automatic wait_rdy(input string name);
        int n;
        n = 0;
        while (!cmd_rdy && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_rdy) begin
            checks++;
            errors++;
            $display("FAIL %s actual=cmd_rdy_low required=cmd_rdy_high", name);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd"}, 32'(cmd), 32'h00);
        chk({tag, "_data"}, 32'(data), 32'h0000);
        chk({tag, "_cmd_rdy"}, 32'(cmd_rdy), 32'd0);
        chk({tag, "_resp_sent"}, 32'(resp_sent), 32'd0);
        chk({tag, "_tx"}, 32'(TX), 32'd1);
    endtask

    // Drive one response and sample TX mid-bit; optionally retrigger mid-frame
    task automatic resp_test(input logic [7:0] r, input bit inject);
        logic [9:0] f;
        f = {1'b1, r, 1'b0};
        @(negedge clk);
        resp      = r;
        send_resp = 1'b1;
        for (int n = 1; n <= int'(FRAME) + 1; n++) begin
            @(negedge clk);
            if (n == 1) begin
                send_resp = 1'b0;
                chk("resp_sent_clr", 32'(resp_sent), 32'd0);
            end
            if ((n - 1) % int'(BD) == int'(BD / 2)) begin
                chk($sformatf("tx_bit%0d", (n - 1) / int'(BD)), 32'(TX), 32'(f[(n - 1) / int'(BD)]));
            end
            if (inject && n == 3 * int'(BD)) begin
                resp      = ~r;
                send_resp = 1'b1;
            end
            if (inject && n == 3 * int'(BD) + 1) begin
                resp      = r;
                send_resp = 1'b0;
            end
            if (n == int'(FRAME)) chk("resp_sent_early", 32'(resp_sent), 32'd0);
            if (n == int'(FRAME) + 1) chk("resp_sent_set", 32'(resp_sent), 32'd1);
        end
        chk("tx_idle", 32'(TX), 32'd1);
    endtask

    initial begin
        vecs[0] = '{8'h05, 8'h00, 8'hFF, 8'h05, 16'h00FF, 1'b1};
        vecs[1] = '{8'h02, 8'h01, 8'h00, 8'h02, 16'h0100, 1'b0};
        vecs[2] = '{8'h03, 8'hFF, 8'h80, 8'h03, 16'hFF80, 1'b0};
        vecs[3] = '{8'h04, 8'h00, 8'h80, 8'h04, 16'h0080, 1'b0};
        vecs[4] = '{8'h08, 8'h00, 8'h00, 8'h08, 16'h0000, 1'b1};

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Packet table, bytes sent with no idle gap between packets
        for (int i = 0; i < 5; i++) begin
            push(vecs[i].exp_cmd, vecs[i].exp_data);
            send_byte(vecs[i].b0);
            if (i > 0 && !vecs[i - 1].clr_after) begin
                chk($sformatf("v%0d_rdy_drop", i), 32'(cmd_rdy), 32'd0);
                chk($sformatf("v%0d_cmd_hold", i), 32'(cmd), 32'(vecs[i - 1].exp_cmd));
                chk($sformatf("v%0d_data_hold", i), 32'(data), 32'(vecs[i - 1].exp_data));
            end
            send_byte(vecs[i].b1);
            send_byte(vecs[i].b2);
            wait_rdy($sformatf("v%0d_wait", i));
            chk($sformatf("v%0d_cmd", i), 32'(cmd), 32'(vecs[i].exp_cmd));
            chk($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
            if (vecs[i].clr_after) begin
                @(negedge clk);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                chk($sformatf("v%0d_clr", i), 32'(cmd_rdy), 32'd0);
                chk($sformatf("v%0d_clr_cmd", i), 32'(cmd), 32'(vecs[i].exp_cmd));
            end
        end

        // Responses
        repeat (10) @(negedge clk);
        resp_test(8'hA5, 1'b1);
        repeat (5) @(negedge clk);
        resp_test(8'h5A, 1'b0);

        // Inter-byte gap longer than the timeout
`ifdef CMD_TIMEOUT_EN
        push(8'h06, 16'h0000);
`else
        push(8'h02, 16'h0106);
`endif
        send_byte(8'h02);
        send_byte(8'h01);
        repeat (int'(TO) + 10) @(negedge clk);
        send_byte(8'h06);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (BD) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
        chk("to_cmd", 32'(cmd), 32'h06);
        chk("to_data", 32'(data), 32'h0000);
        chk("to_rdy", 32'(cmd_rdy), 32'd1);
`else
        chk("to_cmd", 32'(cmd), 32'h02);
        chk("to_data", 32'(data), 32'h0106);
        chk("to_rdy", 32'(cmd_rdy), 32'd0);
        // realign to a packet boundary: {00, 00, 00}
        push(8'h00, 16'h0000);
        send_byte(8'h00);
        repeat (BD) @(negedge clk);
`endif

        // Reset in the middle of a packet
        send_byte(8'h05);
        send_byte(8'h12);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst_mid");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push(8'h07, 16'h0000);
        send_byte(8'h07);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_rdy("rst_pkt_wait");
        chk("rst_pkt_cmd", 32'(cmd), 32'h07);
        chk("rst_pkt_data", 32'(data), 32'h0000);
        chk("rst_pkt_rdy", 32'(cmd_rdy), 32'd1);

        repeat (BD) @(negedge clk);
        chk("sb_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_wrapper.md
# uart_cmd_wrapper

Packet-level front end between the host serial link and the flight command processor. Receives three-byte command packets (command byte, data high byte, data low byte) over an 8N1 UART line. Presents them as a single `cmd`/`data` pair with a `cmd_rdy` flag, and transmits one-byte responses back to the host. Sits between the `RX`/`TX` pins of `QuadCopter` and the command configuration logic.

## Interface
- `BAUD_DIV`, 2604: clocks per bit (50 MHz / 19200 baud).
- `TIMEOUT_CYC`, 24'd2_500_000: maximum idle clocks between bytes of one packet (50 ms). Used only with `CMD_TIMEOUT_EN`.
- `clk`  in  1: system clock, 50 MHz.
- `rst_n`  in  1: asynchronous active-low reset.
- `RX`  in  1: serial input from host, idle high.
- `TX`  out  1: serial output to host, idle high.
- `cmd`  out  8: command byte of the last complete packet.
- `data`  out  16: data of the last complete packet, {byte2, byte3}.
- `cmd_rdy`  out  1: complete packet available; level signal.
- `clr_cmd_rdy`  in  1: consumer acknowledge; knocks down `cmd_rdy`.
- `resp`  in  8: response byte to transmit.
- `send_resp`  in  1: one-cycle pulse that starts transmission of `resp`.
- `resp_sent`  out  1: response frame finished; level signal, cleared by the next `send_resp`.

## Operation
- Byte layer:
  - The `uart` sub-module provides `rx_data[7:0]`, `rx_rdy` and `clr_rx_rdy`.
  - `RX` is double-flopped before start-bit detection.
  - The wrapper asserts `clr_rx_rdy` in the same cycle it consumes a byte.
- Packet FSM states: `IDLE`, `WAIT_HI`, `WAIT_LO`.
  - `IDLE` + `rx_rdy`: capture `cmd_shadow <= rx_data`, clear `cmd_rdy`, go to `WAIT_HI`.
  - `WAIT_HI` + `rx_rdy`: capture `data_hi <= rx_data`, go to `WAIT_LO`.
  - `WAIT_LO` + `rx_rdy`: load `cmd <= cmd_shadow` and `data <= {data_hi, rx_data}`, set `cmd_rdy`, go to `IDLE`.
- `cmd`/`data` update only on packet completion, so they are stable while `cmd_rdy` is high.
- `cmd_rdy` clears on `clr_cmd_rdy`, or on receipt of the first byte of the next packet.
- Packet completion while `cmd_rdy` is already high: `cmd`/`data` are overwritten and `cmd_rdy` stays high. There is no overrun flag.
- Simultaneous packet completion and `clr_cmd_rdy`: set wins; `cmd_rdy` = 1 with the new values.
- Response path:
  - `send_resp` while the transmitter is idle loads `resp`, clears `resp_sent`, and starts the frame: start bit, 8 data bits LSB first, stop bit.
  - `resp_sent` sets in the cycle after the stop bit completes.
  - `send_resp` while a frame is in progress is ignored.
- Reset values: `cmd` = 8'h00, `data` = 16'h0000, `cmd_rdy` = 0, `resp_sent` = 0, `TX` = 1, FSM = `IDLE`, shadow registers cleared.
- Reset mid-packet discards any partial packet. Reset mid-frame drives `TX` high immediately.

## Timing
- Byte time: 10·`BAUD_DIV` clocks. RX samples each bit at `BAUD_DIV`/2.
- `cmd_rdy` rises exactly 1 clock after `rx_rdy` for the third byte, which is mid-stop-bit.
- `clr_cmd_rdy` high in cycle n gives `cmd_rdy` low in cycle n+1.
- `TX` start bit begins 1 clock after `send_resp`. `resp_sent` rises 10·`BAUD_DIV`+1 clocks after `send_resp`.
- Back-to-back packets with no idle gap are supported; no byte is lost.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - A 24-bit gap counter runs in `WAIT_HI`/`WAIT_LO`, resetting on each `rx_rdy`.
  - When it reaches `TIMEOUT_CYC`, the FSM returns to `IDLE` and the partial packet is discarded. `cmd`, `data` and `cmd_rdy` are untouched.
  - Counter and `rx_rdy` in the same cycle: the byte is accepted.
- Not defined: no counter is instantiated; the FSM waits indefinitely for the remaining bytes.

## Structure
- Shared package `quad_pkg`:
  - FSM state enum `pkt_state_t`.
  - `PKT_BYTES` = 3.
  - Default `BAUD_DIV`.
  - Command encodings 8'h02–8'h08 (`STPTCH` … `MTSOFF`), used by consumers and benches.
- One sub-module: `uart`, the byte transceiver (8N1 RX and TX, parameter `BAUD_DIV`). The packet FSM, shadow registers and timeout live in `uart_cmd_wrapper`.

## Test plan
- **Basic packet:** after reset, host sends 8'h05, 8'h00, 8'hFF -> `cmd` = 8'h05, `data` = 16'h00FF, `cmd_rdy` rises 1 clock after the third `rx_rdy`.
- **Clear and back-to-back:** after the basic packet, pulse `clr_cmd_rdy` -> `cmd_rdy` = 0 next cycle. Then send 8'h02, 8'h01, 8'h00 with no gap, followed by 8'h03, 8'hFF, 8'h80 -> `cmd`/`data` = 8'h03 / 16'hFF80 after the second packet, and `cmd_rdy` was cleared at that packet's first byte.
- **Response:** `send_resp` with `resp` = 8'hA5 -> `TX` shows bits 1,0,1,0,0,1,0,1 (LSB first) between start and stop bits. `resp_sent` = 1 at 10·`BAUD_DIV`+1 clocks. A second `send_resp` mid-frame is ignored.
- **Timeout (`CMD_TIMEOUT_EN`):** send 8'h02, 8'h01, idle for `TIMEOUT_CYC`+10 clocks, then send 8'h06, 8'h00, 8'h00 -> `cmd` = 8'h06, `data` = 16'h0000. Without the macro the same stimulus yields `cmd` = 8'h02, `data` = 16'h0106.
- **Reset mid-packet:** send 8'h05, 8'h12, assert `rst_n` low for 2 clocks, then send 8'h07, 8'h00, 8'h00 -> all outputs at reset values after reset, then `cmd` = 8'h07, `data` = 16'h0000, `cmd_rdy` = 1.
- **Overwrite:** complete two packets (8'h04, 8'h00, 8'h80 then 8'h08, 8'h00, 8'h00) without `clr_cmd_rdy` -> `cmd_rdy` drops at the second packet's first byte. Final state: `cmd` = 8'h08, `data` = 16'h0000, `cmd_rdy` = 1.
